unidad_control_multiciclo: RTL and testbench

Multicycle MIPS-subset control unit that sequences the shared datapath (PC, IR, register file, single ALU, unified memory) one instruction at a time. It decodes the 6-bit opcode into a Moore state machine and drives every datapath enable and mux select. It produces the 3-bit `codigo_UC` consumed by `ControladorALU`, which turns it into the ALU operation. It also stalls on a memory ready handshake and traps unsupported opcodes.

---
 rtl/unidad_control_multiciclo_pkg.sv | 45 ++++
 rtl/unidad_control_multiciclo_decodificador_salidas.sv | 97 +++++++++
 rtl/unidad_control_multiciclo.sv | 100 ++++++++++
 tb/tb_unidad_control_multiciclo.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/unidad_control_multiciclo_pkg.sv
// Shared definitions for the multicycle MIPS-subset control unit.
//   - estado_t: FSM state encodings (INICIO..ERROR, 4 bits, 14-15 unused)
//   - opcode constants for the supported instructions
//   - codigo_UC values handed to ControladorALU
//   - alu_src_b and pc_fuente mux selector encodings
package paquete_control;

  typedef enum logic [3:0] {
    INICIO    = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    EXEC_R    = 4'd7,
    R_WB      = 4'd8,
    EXEC_I    = 4'd9,
    I_WB      = 4'd10,
    BRANCH    = 4'd11,
    JUMP      = 4'd12,
    ERROR     = 4'd13
  } estado_t;

  localparam logic [5:0] OPCODE_R    = 6'b000000;
  localparam logic [5:0] OPCODE_LW   = 6'b100011;
  localparam logic [5:0] OPCODE_SW   = 6'b101011;
  localparam logic [5:0] OPCODE_BEQ  = 6'b000100;
  localparam logic [5:0] OPCODE_ADDI = 6'b001000;
  localparam logic [5:0] OPCODE_J    = 6'b000010;

  localparam logic [2:0] UC_R       = 3'b000;
  localparam logic [2:0] UC_ADD     = 3'b001;
  localparam logic [2:0] UC_NINGUNA = 3'b010;

  localparam logic [1:0] ALU_B_REG        = 2'b00;
  localparam logic [1:0] ALU_B_CUATRO     = 2'b01;
  localparam logic [1:0] ALU_B_INMED      = 2'b10;
  localparam logic [1:0] ALU_B_INMED_DESP = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SALTO  = 2'b10;

endpackage

// File: rtl/unidad_control_multiciclo_decodificador_salidas.sv
// Purely combinational Moore decode of the control word from the current
// state. Only the FETCH PC/IR loads (gated by mem_listo) and the BRANCH PC
// load (gated by iguales) depend on inputs.
// Ports:
//   estado        in  4  current FSM state (14-15 decode like ERROR)
//   mem_listo     in  1  memory handshake
//   iguales       in  1  A == B from the datapath comparator
//   codigo_UC .. excepcion  out  datapath control word
module decodificador_salidas
  import paquete_control::*;
(
  input  logic [3:0] estado,
  input  logic       mem_listo,
  input  logic       iguales,
  output logic [2:0] codigo_UC,
  output logic       pc_escribir,
  output logic       ir_escribir,
  output logic       mem_leer,
  output logic       mem_escribir,
  output logic       i_o_d,
  output logic       reg_escribir,
  output logic       reg_dst,
  output logic       mem_a_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_fuente,
  output logic       excepcion
);

  always_comb begin
    codigo_UC    = UC_NINGUNA;
    pc_escribir  = 1'b0;
    ir_escribir  = 1'b0;
    mem_leer     = 1'b0;
    mem_escribir = 1'b0;
    i_o_d        = 1'b0;
    reg_escribir = 1'b0;
    reg_dst      = 1'b0;
    mem_a_reg    = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = ALU_B_REG;
    pc_fuente    = PC_ALU;
    excepcion    = 1'b0;

    case (estado_t'(estado))
      INICIO: ;
      FETCH: begin
        mem_leer    = 1'b1;
        alu_src_b   = ALU_B_CUATRO;
        codigo_UC   = UC_ADD;
        // PC+4 and the fetched word are captured only on the ready cycle
        ir_escribir = mem_listo;
        pc_escribir = mem_listo;
      end
      DECODE: begin
        alu_src_b = ALU_B_INMED_DESP;
        codigo_UC = UC_ADD;
      end
      MEM_ADDR, EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_B_INMED;
        codigo_UC = UC_ADD;
      end
      MEM_READ: begin
        mem_leer = 1'b1;
        i_o_d    = 1'b1;
      end
      MEM_WB: begin
        reg_escribir = 1'b1;
        mem_a_reg    = 1'b1;
      end
      MEM_WRITE: begin
        mem_escribir = 1'b1;
        i_o_d        = 1'b1;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        codigo_UC = UC_R;
      end
      R_WB: begin
        reg_escribir = 1'b1;
        reg_dst      = 1'b1;
      end
      I_WB: reg_escribir = 1'b1;
      BRANCH: begin
        pc_fuente   = PC_ALUOUT;
        pc_escribir = iguales;
      end
      JUMP: begin
        pc_fuente   = PC_SALTO;
        pc_escribir = 1'b1;
      end
      default: excepcion = 1'b1;
    endcase
  end

endmodule

// File: rtl/unidad_control_multiciclo.sv
// Multicycle MIPS-subset control unit: state register and next-state logic.
// The control word is produced by decodificador_salidas.
// Ports:
//   clk, reset (sync, active-high)
//   opcode     in  6  IR[31:26], valid from DECODE onward
//   iguales    in  1  A == B
//   mem_listo  in  1  memory completed this cycle
//   codigo_UC, pc_escribir, ir_escribir, mem_leer, mem_escribir, i_o_d,
//   reg_escribir, reg_dst, mem_a_reg, alu_src_a, alu_src_b, pc_fuente,
//   excepcion  out  datapath control word
//   estado     out  4  current state for debug
module unidad_control_multiciclo
  import paquete_control::*;
#(
  parameter logic [5:0] OP_R    = OPCODE_R,
  parameter logic [5:0] OP_LW   = OPCODE_LW,
  parameter logic [5:0] OP_SW   = OPCODE_SW,
  parameter logic [5:0] OP_BEQ  = OPCODE_BEQ,
  parameter logic [5:0] OP_ADDI = OPCODE_ADDI,
  parameter logic [5:0] OP_J    = OPCODE_J
)(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       iguales,
  input  logic       mem_listo,
  output logic [2:0] codigo_UC,
  output logic       pc_escribir,
  output logic       ir_escribir,
  output logic       mem_leer,
  output logic       mem_escribir,
  output logic       i_o_d,
  output logic       reg_escribir,
  output logic       reg_dst,
  output logic       mem_a_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_fuente,
  output logic       excepcion,
  output logic [3:0] estado
);

  estado_t estado_q;
  estado_t estado_d;

  always_ff @(posedge clk) begin
    if (reset) estado_q <= INICIO;
    else       estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIO:   estado_d = FETCH;
      FETCH:    if (mem_listo) estado_d = DECODE;
      DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW) estado_d = MEM_ADDR;
        else if (opcode == OP_R)                estado_d = EXEC_R;
        else if (opcode == OP_ADDI)             estado_d = EXEC_I;
        else if (opcode == OP_BEQ)              estado_d = BRANCH;
        else if (opcode == OP_J)                estado_d = JUMP;
        else                                    estado_d = ERROR;
      end
      MEM_ADDR:  estado_d = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ:  if (mem_listo) estado_d = MEM_WB;
      MEM_WB:    estado_d = FETCH;
      MEM_WRITE: if (mem_listo) estado_d = FETCH;
      EXEC_R:    estado_d = R_WB;
      R_WB:      estado_d = FETCH;
      EXEC_I:    estado_d = I_WB;
      I_WB:      estado_d = FETCH;
      BRANCH:    estado_d = FETCH;
      JUMP:      estado_d = FETCH;
      // ERROR and the unused encodings only leave through reset
      default:   estado_d = ERROR;
    endcase
  end

  assign estado = estado_q;

  decodificador_salidas u_salidas (
    .estado       (estado_q),
    .mem_listo    (mem_listo),
    .iguales      (iguales),
    .codigo_UC    (codigo_UC),
    .pc_escribir  (pc_escribir),
    .ir_escribir  (ir_escribir),
    .mem_leer     (mem_leer),
    .mem_escribir (mem_escribir),
    .i_o_d        (i_o_d),
    .reg_escribir (reg_escribir),
    .reg_dst      (reg_dst),
    .mem_a_reg    (mem_a_reg),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .pc_fuente    (pc_fuente),
    .excepcion    (excepcion)
  );

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Directed bench for unidad_control_multiciclo: each cycle's expected state
// and control word are queued as the inputs are driven, then popped and
// compared at the falling edge.
module tb_unidad_control_multiciclo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       iguales = 1'b0;
  logic       mem_listo = 1'b0;
  logic [2:0] codigo_UC;
  logic       pc_escribir, ir_escribir, mem_leer, mem_escribir, i_o_d;
  logic       reg_escribir, reg_dst, mem_a_reg, alu_src_a, excepcion;
  logic [1:0] alu_src_b, pc_fuente;
  logic [3:0] estado;

  unidad_control_multiciclo dut (
    .clk(clk), .reset(reset), .opcode(opcode), .iguales(iguales),
    .mem_listo(mem_listo), .codigo_UC(codigo_UC), .pc_escribir(pc_escribir),
    .ir_escribir(ir_escribir), .mem_leer(mem_leer), .mem_escribir(mem_escribir),
    .i_o_d(i_o_d), .reg_escribir(reg_escribir), .reg_dst(reg_dst),
    .mem_a_reg(mem_a_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_fuente(pc_fuente), .excepcion(excepcion), .estado(estado)
  );

  always #5 clk = ~clk;

  logic [16:0] obs;
  assign obs = {codigo_UC, pc_escribir, ir_escribir, mem_leer, mem_escribir,
                i_o_d, reg_escribir, reg_dst, mem_a_reg, alu_src_a,
                alu_src_b, pc_fuente, excepcion};

  typedef struct packed {
    logic [3:0]  e;
    logic [16:0] w;
  } esperado_t;

  esperado_t sb[$];
  string     tags[$];
  int        n_pass = 0;
  int        n_total = 0;
  int        n_pcw = 0;
  int        n_regw = 0;

  function automatic logic [16:0] cw(
    input logic [2:0] uc, input logic pcw, input logic irw, input logic ml,
    input logic me, input logic iod, input logic rw, input logic rd,
    input logic m2r, input logic asa, input logic [1:0] asb,
    input logic [1:0] pcf, input logic exc);
    return {uc, pcw, irw, ml, me, iod, rw, rd, m2r, asa, asb, pcf, exc};
  endfunction

  logic [16:0] W_INICIO, W_FETCH_WAIT, W_FETCH_OK, W_DECODE, W_ADDR, W_MEMR;
  logic [16:0] W_MEMWB, W_MEMW, W_EXECR, W_RWB, W_IWB, W_BR_T, W_BR_N, W_JUMP;
  logic [16:0] W_ERROR;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    n_total = n_total + 1;
    assert (got === want) n_pass = n_pass + 1;
    else $error("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  task automatic ciclo(input logic rst, input logic ml, input logic ig,
                       input logic [5:0] op, input logic [3:0] e,
                       input logic [16:0] w, input string tag);
    esperado_t x;
    string     t;
    reset = rst; mem_listo = ml; iguales = ig; opcode = op;
    sb.push_back('{e: e, w: w});
    tags.push_back(tag);
    @(negedge clk);
    x = sb.pop_front();
    t = tags.pop_front();
    check({t, ".estado"}, {28'd0, estado}, {28'd0, x.e});
    check({t, ".ctrl"}, {15'd0, obs}, {15'd0, x.w});
    if (pc_escribir === 1'b1) n_pcw = n_pcw + 1;
    if (reg_escribir === 1'b1) n_regw = n_regw + 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pc0, rw0;
    //             uc     pcw  irw  ml   me   iod  rw   rd   m2r  asa  asb    pcf    exc
    W_INICIO     = cw(3'b010,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0);
    W_FETCH_WAIT = cw(3'b001,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0);
    W_FETCH_OK   = cw(3'b001,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0);
    W_DECODE     = cw(3'b001,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,1'b0);
    W_ADDR       = cw(3'b001,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,1'b0);
    W_MEMR       = cw(3'b010,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0);
    W_MEMWB      = cw(3'b010,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0);
    W_MEMW       = cw(3'b010,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0);
    W_EXECR      = cw(3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0);
    W_RWB        = cw(3'b010,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0);
    W_IWB        = cw(3'b010,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0);
    W_BR_T       = cw(3'b010,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,1'b0);
    W_BR_N       = cw(3'b010,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,1'b0);
    W_JUMP       = cw(3'b010,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,1'b0);
    W_ERROR      = cw(3'b010,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1);

    repeat (2) @(posedge clk);
    #1;

    // Reset held, then R-type: 0,1,2,7,8,1
    ciclo(1, 1, 0, 6'b000000, 4'd0, W_INICIO, "rst");
    ciclo(0, 1, 0, 6'b000000, 4'd0, W_INICIO, "r.inicio");
    ciclo(0, 1, 0, 6'b000000, 4'd1, W_FETCH_OK, "r.fetch");
    ciclo(0, 1, 0, 6'b000000, 4'd2, W_DECODE, "r.decode");
    ciclo(0, 0, 1, 6'b000000, 4'd7, W_EXECR, "r.exec");
    ciclo(0, 0, 0, 6'b000000, 4'd8, W_RWB, "r.wb");

    // LW with 3 wait cycles in FETCH and in MEM_READ: 11 cycles
    pc0 = n_pcw;
    for (int i = 0; i < 3; i++) ciclo(0, 0, 0, 6'b100011, 4'd1, W_FETCH_WAIT, "lw.fetch_wait");
    ciclo(0, 1, 0, 6'b100011, 4'd1, W_FETCH_OK, "lw.fetch");
    ciclo(0, 0, 0, 6'b100011, 4'd2, W_DECODE, "lw.decode");
    ciclo(0, 1, 0, 6'b100011, 4'd3, W_ADDR, "lw.addr");
    for (int i = 0; i < 3; i++) ciclo(0, 0, 0, 6'b100011, 4'd4, W_MEMR, "lw.read_wait");
    ciclo(0, 1, 0, 6'b100011, 4'd4, W_MEMR, "lw.read");
    ciclo(0, 1, 0, 6'b100011, 4'd5, W_MEMWB, "lw.wb");
    check("lw.pc_writes", n_pcw - pc0, 1);

    // ADDI
    ciclo(0, 1, 0, 6'b001000, 4'd1, W_FETCH_OK, "addi.fetch");
    ciclo(0, 1, 0, 6'b001000, 4'd2, W_DECODE, "addi.decode");
    ciclo(0, 0, 0, 6'b001000, 4'd9, W_ADDR, "addi.exec");
    ciclo(0, 0, 0, 6'b001000, 4'd10, W_IWB, "addi.wb");

    // BEQ taken, then not taken
    ciclo(0, 1, 0, 6'b000100, 4'd1, W_FETCH_OK, "beq1.fetch");
    ciclo(0, 0, 1, 6'b000100, 4'd2, W_DECODE, "beq1.decode");
    ciclo(0, 0, 1, 6'b000100, 4'd11, W_BR_T, "beq1.branch");
    ciclo(0, 1, 0, 6'b000100, 4'd1, W_FETCH_OK, "beq0.fetch");
    ciclo(0, 0, 0, 6'b000100, 4'd2, W_DECODE, "beq0.decode");
    ciclo(0, 1, 0, 6'b000100, 4'd11, W_BR_N, "beq0.branch");

    // J: no register writes
    rw0 = n_regw;
    ciclo(0, 1, 0, 6'b000010, 4'd1, W_FETCH_OK, "j.fetch");
    ciclo(0, 1, 0, 6'b000010, 4'd2, W_DECODE, "j.decode");
    ciclo(0, 1, 0, 6'b000010, 4'd12, W_JUMP, "j.jump");
    check("j.reg_writes", n_regw - rw0, 0);

    // SW with zero wait states
    ciclo(0, 1, 0, 6'b101011, 4'd1, W_FETCH_OK, "sw.fetch");
    ciclo(0, 1, 0, 6'b101011, 4'd2, W_DECODE, "sw.decode");
    ciclo(0, 1, 0, 6'b101011, 4'd3, W_ADDR, "sw.addr");
    ciclo(0, 1, 0, 6'b101011, 4'd6, W_MEMW, "sw.write");

    // Illegal opcode: ERROR for 20 cycles, then reset
    ciclo(0, 1, 0, 6'b111111, 4'd1, W_FETCH_OK, "ill.fetch");
    ciclo(0, 1, 0, 6'b111111, 4'd2, W_DECODE, "ill.decode");
    for (int i = 0; i < 20; i++) ciclo(0, i[0], ~i[0], 6'b111111, 4'd13, W_ERROR, "ill.error");
    ciclo(1, 1, 0, 6'b111111, 4'd13, W_ERROR, "ill.rst");
    ciclo(0, 1, 0, 6'b101011, 4'd0, W_INICIO, "ill.inicio");

    // SW stalled, reset during MEM_WRITE abandons it
    pc0 = n_pcw;
    ciclo(0, 1, 0, 6'b101011, 4'd1, W_FETCH_OK, "swr.fetch");
    ciclo(0, 1, 0, 6'b101011, 4'd2, W_DECODE, "swr.decode");
    ciclo(0, 0, 0, 6'b101011, 4'd3, W_ADDR, "swr.addr");
    ciclo(0, 0, 0, 6'b101011, 4'd6, W_MEMW, "swr.wait");
    ciclo(1, 0, 0, 6'b101011, 4'd6, W_MEMW, "swr.rst");
    ciclo(0, 1, 1, 6'b101011, 4'd0, W_INICIO, "swr.inicio");
    check("swr.pc_writes", n_pcw - pc0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
